// File: rtl/imem_burst_pkg.sv
// imem_burst_pkg
//   Shared types and constants for the instruction-memory burst bridge.
//   - state_e          : bridge FSM states
//   - ERR_DATA_DEFAULT : word returned for out-of-range beats (RISC-V NOP)
//   - beat_cnt_w()     : width of a counter that must hold 0..block_size inclusive
package imem_burst_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } state_e;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'h0000_0013;

  // The issue counter has to reach "beats" itself (one past the last index)
  // so the FSM can spend one drain cycle while the final beat is on the bus.
  function automatic int beat_cnt_w(input int block_size);
    return $clog2(block_size + 1);
  endfunction

endpackage

// File: rtl/imem_burst_bridge.sv
// imem_burst_bridge
//   Burst responder behind the icache refill port. Accepts one burst request,
//   reads len+1 consecutive words (clamped to BLOCK_SIZE) from an external
//   synchronous-read RAM and streams them back one beat per cycle. Addresses
//   beyond MEM_WORDS return ERR_DATA and raise mem_err alongside mem_last.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   mem_req           single-cycle burst request (accepted only while mem_ready)
//   mem_addr          burst base byte address (low byte-offset bits ignored)
//   mem_burst_len     beats-1
//   mem_ready         idle, next request will be accepted
//   mem_data/valid    beat data and qualifier, contiguous for the whole burst
//   mem_last/err      final beat marker; err set if any beat was out of range
//   ram_en/ram_addr   RAM read strobe and word address
//   ram_rdata         RAM read data, valid the cycle after ram_en
//
// Build option
//   IMEM_BURST_STATS_EN : adds stat_bursts / stat_beats free-running counters.
//
// state | meaning
// IDLE  | mem_ready high, waiting for mem_req
// WAIT  | first-beat latency countdown
// BURST | one RAM read issued per cycle, then one drain cycle for mem_last
module imem_burst_bridge
  import imem_burst_pkg::*;
#(
  parameter int ADDR_WIDTH         = 32,
  parameter int DATA_WIDTH         = 32,
  parameter int BLOCK_SIZE         = 8,
  parameter int MEM_WORDS          = 4096,
  parameter int FIRST_BEAT_LATENCY = 2,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(ERR_DATA_DEFAULT),
  localparam int RAM_AW = $clog2(MEM_WORDS),
  localparam int LEN_W  = $clog2(BLOCK_SIZE) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_req,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [LEN_W-1:0]      mem_burst_len,
  output logic                  mem_ready,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_valid,
  output logic                  mem_last,
  output logic                  mem_err,
  output logic                  ram_en,
  output logic [RAM_AW-1:0]     ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_rdata
`ifdef IMEM_BURST_STATS_EN
  ,
  output logic [31:0]           stat_bursts,
  output logic [31:0]           stat_beats
`endif
);

  localparam int BYTE_BITS = $clog2(DATA_WIDTH / 8);
  localparam int WORD_AW   = ADDR_WIDTH - BYTE_BITS;
  localparam int CNT_W     = beat_cnt_w(BLOCK_SIZE);
  localparam int WAIT_W    = (FIRST_BEAT_LATENCY > 1) ? $clog2(FIRST_BEAT_LATENCY) : 1;

  state_e             state_q, state_d;
  logic [WORD_AW-1:0] base_q, base_d;
  logic [CNT_W-1:0]   beats_q, beats_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               err_q, err_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               merr_q, merr_d;
  logic               oor_q, oor_d;

  logic               accept;
  logic               issue;
  logic               issue_last;
  logic               beat_oor;
  logic [WORD_AW-1:0] beat_addr;
  logic [LEN_W:0]     len_p1;
  logic [CNT_W-1:0]   beats_req;
  logic               unused_addr_lsb;

  assign unused_addr_lsb = ^mem_addr[BYTE_BITS-1:0];

  assign mem_ready = (state_q == IDLE);
  assign accept    = mem_ready && mem_req;

  // len+1 is computed one bit wider so len = all-ones does not wrap to zero
  assign len_p1    = {1'b0, mem_burst_len} + (LEN_W + 1)'(1);
  assign beats_req = (len_p1 > (LEN_W + 1)'(BLOCK_SIZE)) ? CNT_W'(BLOCK_SIZE)
                                                          : CNT_W'(len_p1);

  // word address wraps naturally at the word-address width
  assign beat_addr  = base_q + WORD_AW'(idx_q);
  assign beat_oor   = (beat_addr >= WORD_AW'(MEM_WORDS));
  assign issue      = (state_q == BURST) && (idx_q != beats_q);
  assign issue_last = issue && (idx_q == beats_q - CNT_W'(1));

  assign ram_en   = issue && !beat_oor;
  assign ram_addr = ram_en ? beat_addr[RAM_AW-1:0] : '0;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    beats_d = beats_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    err_d   = err_q;
    valid_d = issue;
    last_d  = issue_last;
    oor_d   = issue && beat_oor;
    merr_d  = issue_last && (err_q || beat_oor);

    case (state_q)
      IDLE: begin
        if (mem_req) begin
          base_d  = mem_addr[ADDR_WIDTH-1:BYTE_BITS];
          beats_d = beats_req;
          idx_d   = '0;
          err_d   = 1'b0;
          if (FIRST_BEAT_LATENCY == 0) begin
            state_d = BURST;
          end else begin
            wait_d  = WAIT_W'(FIRST_BEAT_LATENCY - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (wait_q == '0) begin
          state_d = BURST;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      BURST: begin
        if (issue) begin
          idx_d = idx_q + CNT_W'(1);
          if (beat_oor) begin
            err_d = 1'b1;
          end
        end else begin
          // drain cycle: the final beat is on the bus now
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      beats_q <= '0;
      idx_q   <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      merr_q  <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      beats_q <= beats_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      merr_q  <= merr_d;
      oor_q   <= oor_d;
    end
  end

  // RAM data arrives in the same cycle the registered beat qualifiers do
  assign mem_valid = valid_q;
  assign mem_last  = last_q;
  assign mem_err   = merr_q;
  assign mem_data  = valid_q ? (oor_q ? ERR_DATA : ram_rdata) : '0;

`ifdef IMEM_BURST_STATS_EN
  logic [31:0] stat_bursts_q;
  logic [31:0] stat_beats_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_bursts_q <= '0;
      stat_beats_q  <= '0;
    end else begin
      if (accept) begin
        stat_bursts_q <= stat_bursts_q + 32'd1;
      end
      if (valid_q) begin
        stat_beats_q <= stat_beats_q + 32'd1;
      end
    end
  end

  assign stat_bursts = stat_bursts_q;
  assign stat_beats  = stat_beats_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_imem_burst_bridge.sv
// tb_imem_burst_bridge
//   Scoreboard bench for imem_burst_bridge. Main instance uses
//   FIRST_BEAT_LATENCY=2; a second instance with latency 0 covers the
//   single-beat, zero-wait path. Behavioural sync-read RAMs return a
//   deterministic pattern derived from the word address.
`timescale 1ns/1ps
module tb_imem_burst_bridge;
  import imem_burst_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BS  = 8;
  localparam int MW  = 4096;
  localparam int LAT = 2;
  localparam int RAW = $clog2(MW);
  localparam int LW  = $clog2(BS) + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req, ready, valid, last, err, ram_en;
  logic [AW-1:0] addr;
  logic [LW-1:0] len;
  logic [DW-1:0] data, rdata;
  logic [RAW-1:0] ram_addr;

  logic          zreq, zready, zvalid, zlast, zerr, zram_en;
  logic [AW-1:0] zaddr;
  logic [LW-1:0] zlen;
  logic [DW-1:0] zdata, zrdata;
  logic [RAW-1:0] zram_addr;

`ifdef IMEM_BURST_STATS_EN
  logic [31:0] stat_bursts, stat_beats, zstat_bursts, zstat_beats;
`endif

  imem_burst_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_SIZE(BS),
                      .MEM_WORDS(MW), .FIRST_BEAT_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .mem_req(req), .mem_addr(addr), .mem_burst_len(len),
    .mem_ready(ready), .mem_data(data), .mem_valid(valid), .mem_last(last),
    .mem_err(err), .ram_en(ram_en), .ram_addr(ram_addr), .ram_rdata(rdata)
`ifdef IMEM_BURST_STATS_EN
    , .stat_bursts(stat_bursts), .stat_beats(stat_beats)
`endif
  );

  imem_burst_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_SIZE(BS),
                      .MEM_WORDS(MW), .FIRST_BEAT_LATENCY(0)) dut_z (
    .clk(clk), .rst(rst), .mem_req(zreq), .mem_addr(zaddr), .mem_burst_len(zlen),
    .mem_ready(zready), .mem_data(zdata), .mem_valid(zvalid), .mem_last(zlast),
    .mem_err(zerr), .ram_en(zram_en), .ram_addr(zram_addr), .ram_rdata(zrdata)
`ifdef IMEM_BURST_STATS_EN
    , .stat_bursts(zstat_bursts), .stat_beats(zstat_beats)
`endif
  );

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[15:0] + 16'h1357};
  endfunction

  always @(posedge clk) if (ram_en)  rdata  <= ram_word(32'(ram_addr));
  always @(posedge clk) if (zram_en) zrdata <= ram_word(32'(zram_addr));

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        err;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_b;
  int    exp_bursts = 0;
  int    exp_beats  = 0;
  int    beats_seen = 0;
  int    ram_en_cnt = 0;
  logic  prev_open  = 1'b0;
  logic  last_seen  = 1'b0;

  task automatic push_burst(input logic [31:0] a, input int l);
    int          beats;
    logic [29:0] w;
    logic        any;
    beats = (l + 1 > BS) ? BS : l + 1;
    w     = a[31:2];
    any   = 1'b0;
    for (int i = 0; i < beats; i++) begin
      logic [29:0] wi;
      logic        oor;
      beat_t       b;
      wi  = w + 30'(i);
      oor = (wi >= 30'(MW));
      any = any | oor;
      b.data = oor ? NOP : ram_word({2'b00, wi});
      b.last = (i == beats - 1);
      b.err  = b.last & any;
      exp_q.push_back(b);
    end
    exp_bursts++;
    exp_beats += beats;
  endtask

  // Monitor: pops one expected beat per observed mem_valid.
  always @(negedge clk) begin
    if (rst) begin
      prev_open = 1'b0;
      last_seen = 1'b0;
    end else begin
      if (last_seen) check_eq("ready_after_last", 64'(ready), 64'd1);
      last_seen = 1'b0;
      if (prev_open) check_eq("contiguous", 64'(valid), 64'd1);
      prev_open = 1'b0;
      if (ram_en) ram_en_cnt++;
      if (valid) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          check_eq("spurious_beat", 64'(valid), 64'd0);
        end else begin
          mon_b = exp_q.pop_front();
          check_eq("beat_data", 64'(data), 64'(mon_b.data));
          check_eq("beat_last", 64'(last), 64'(mon_b.last));
          check_eq("beat_err",  64'(err),  64'(mon_b.err));
          if (mon_b.last) begin
            check_eq("ready_during_last", 64'(ready), 64'd0);
            last_seen = 1'b1;
          end else begin
            prev_open = 1'b1;
          end
        end
      end
    end
  end

  // Call at a negedge; returns at the negedge of the first beat.
  task automatic send(input logic [31:0] a, input int l);
    int n;
    int lat;
    n = 0;
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("ready_wait", 64'(ready), 64'd1);
    addr = a;
    len  = LW'(l);
    req  = 1'b1;
    push_burst(a, l);
    @(posedge clk);
    #1 req = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!valid && lat < 50);
    check_eq("first_beat_lat", 64'(lat), 64'(LAT + 2));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bs0;
    rst = 1'b1;
    req = 1'b0; addr = '0; len = '0;
    zreq = 1'b0; zaddr = '0; zlen = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready",    64'(ready),    64'd1);
    check_eq("rst_valid",    64'(valid),    64'd0);
    check_eq("rst_last",     64'(last),     64'd0);
    check_eq("rst_err",      64'(err),      64'd0);
    check_eq("rst_ram_en",   64'(ram_en),   64'd0);
    check_eq("rst_data",     64'(data),     64'd0);
    check_eq("rst_ram_addr", 64'(ram_addr), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: aligned 8-beat burst
    ram_en_cnt = 0;
    send(32'h40, 7);
    drain();
    check_eq("t1_ram_en_cnt", 64'(ram_en_cnt), 64'd8);

    // 2: zero-latency single beat
    zaddr = 32'h1C; zlen = '0; zreq = 1'b1;
    @(posedge clk);
    #1 zreq = 1'b0;
    @(negedge clk);
    check_eq("t2_ram_en",   64'(zram_en),   64'd1);
    check_eq("t2_ram_addr", 64'(zram_addr), 64'd7);
    check_eq("t2_no_early", 64'(zvalid),    64'd0);
    @(negedge clk);
    check_eq("t2_valid", 64'(zvalid), 64'd1);
    check_eq("t2_last",  64'(zlast),  64'd1);
    check_eq("t2_err",   64'(zerr),   64'd0);
    check_eq("t2_data",  64'(zdata),  64'(ram_word(32'd7)));
    @(negedge clk);
    check_eq("t2_ready", 64'(zready), 64'd1);
    check_eq("t2_idle",  64'(zvalid), 64'd0);

    // 3: burst running off the end of the RAM
    ram_en_cnt = 0;
    send(32'((MW - 4) * 4), 7);
    drain();
    check_eq("t3_ram_en_cnt", 64'(ram_en_cnt), 64'd4);

    // 4: stray request mid-burst must be dropped
    send(32'h200, 7);
    addr = 32'h800; len = LW'(3); req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    drain();
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (ready && !valid) n++;
    end
    check_eq("t4_quiet", 64'(n), 64'd10);

    // 5: len beyond BLOCK_SIZE clamps
    ram_en_cnt = 0;
    send(32'h300, 15);
    drain();
    check_eq("t5_ram_en_cnt", 64'(ram_en_cnt), 64'd8);

    // back-to-back misses
    for (int k = 0; k < 6; k++) begin
      logic [31:0] a;
      a = (k == 3) ? 32'((MW - 2) * 4 + 3) : {18'd0, 12'($urandom_range(0, MW - 1)), 2'($urandom)};
      send(a, int'($urandom_range(0, 15)));
    end
    drain();

    // 6: reset mid-burst
    bs0 = beats_seen;
    send(32'h500, 7);
    n = 0;
    while (beats_seen < bs0 + 3 && n < 50) begin
      @(negedge clk);
      #1 n++;
    end
    check_eq("t6_reached_beat3", 64'(beats_seen - bs0), 64'd3);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_eq("t6_ready",    64'(ready),    64'd1);
    check_eq("t6_valid",    64'(valid),    64'd0);
    check_eq("t6_last",     64'(last),     64'd0);
    check_eq("t6_err",      64'(err),      64'd0);
    check_eq("t6_ram_en",   64'(ram_en),   64'd0);
    check_eq("t6_data",     64'(data),     64'd0);
    check_eq("t6_ram_addr", 64'(ram_addr), 64'd0);
    exp_q.delete();
    exp_bursts = 0;
    exp_beats  = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("t6_idle_after", 64'(ready), 64'd1);
    send(32'h600, 5);
    drain();

`ifdef IMEM_BURST_STATS_EN
    check_eq("stat_bursts", 64'(stat_bursts), 64'(exp_bursts));
    check_eq("stat_beats",  64'(stat_beats),  64'(exp_beats));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
